// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (arbiter FSM encoding, default byte width, pointer helper).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int D_BIT_DEF = 8;

    // Arbiter FSM encoding; kept as plain constants so older UART blocks can reuse it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    // Round-robin pointer step: v+1 wrapped at n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
        if (int'(v) >= n - 1) begin
            return 3'd0;
        end
        return v + 3'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: bundle of requester handshake and UART transmitter signals for uart_tx_arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req and data until ack; the transmitter paces via tx_done_tick.
// Ports: req/req_data/ack (requester side), err/busy/grant_idx (status),
//        tx_start_n/tx_data/tx_done_tick (transmitter side).
//        slave = arbiter view, master = requester/transmitter environment view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int D_BIT = uart_pkg::D_BIT_DEF
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*D_BIT-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   err;
    logic                   busy;
    logic [2:0]             grant_idx;
    logic                   tx_start_n;
    logic [D_BIT-1:0]       tx_data;
    logic                   tx_done_tick;

    modport slave (
        input  req, req_data, tx_done_tick,
        output ack, err, busy, grant_idx, tx_start_n, tx_data
    );

    modport master (
        output req, req_data, tx_done_tick,
        input  ack, err, busy, grant_idx, tx_start_n, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: wrapped priority search: first set req bit at or above ptr, wrapping past N_REQ-1.
// Latency: combinational.
// Backpressure: none; vld low when no request is pending.
// Ports: req (request levels), ptr (search start), idx (winner), vld (any request).
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       idx,
    output logic             vld
);

    // Zero-extended to 8 so a 3-bit position indexes it exactly for any N_REQ.
    logic [7:0] req_ext;
    logic [3:0] pos;

    assign req_ext = 8'(req);

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        idx = 3'd0;
        vld = 1'b0;
        pos = 4'd0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            pos = {1'b0, ptr} + 4'(off);
            if (pos >= 4'(N_REQ)) begin
                pos = pos - 4'(N_REQ);
            end
            if (req_ext[pos[2:0]]) begin
                idx = pos[2:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Latency: req seen in IDLE -> tx_start_n low the next cycle; ack one cycle after tx_done_tick.
// Backpressure: requesters hold req until ack; a stalled transmitter is aborted after TIMEOUT cycles (err).
// Ports: clk, rst_n (async active-low), bus (uart_tx_arbiter_if.slave: req/req_data in,
//        ack/err/busy/grant_idx out, tx_start_n/tx_data out, tx_done_tick in).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int D_BIT   = D_BIT_DEF,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 2 ** 20
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [1:0]       state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       pick_idx;
    logic             pick_vld;
    logic [7:0]       ack_hot;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (bus.req),
        .ptr (ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign ack_hot = 8'b1 << bus.grant_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ptr            <= 3'd0;
            cnt            <= '0;
            bus.ack        <= '0;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.grant_idx  <= 3'd0;
            bus.tx_start_n <= 1'b1;
            bus.tx_data    <= '0;
        end else begin
            // Pulse outputs fall back to idle unless a state below asserts them.
            bus.ack        <= '0;
            bus.err        <= 1'b0;
            bus.tx_start_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // tx_done_tick is deliberately not looked at here.
                    if (pick_vld) begin
                        state          <= ST_START;
                        bus.grant_idx  <= pick_idx;
                        bus.tx_data    <= bus.req_data[int'(pick_idx)*D_BIT +: D_BIT];
                        bus.tx_start_n <= 1'b0;
                        bus.busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_BUSY;
                    cnt   <= '0;
                end
                ST_BUSY: begin
                    // Completion beats timeout when both land on the same cycle.
                    if (bus.tx_done_tick) begin
                        bus.ack  <= ack_hot[N_REQ-1:0];
                        ptr      <= wrap_inc(bus.grant_idx, N_REQ);
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.err  <= 1'b1;
                        ptr      <= wrap_inc(bus.grant_idx, N_REQ);
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter D_BIT, default 8: width of one data byte.
REQ-002 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter TIMEOUT, default 2^20: maximum cycles in BUSY before abort, at least 16.
REQ-004 clk  in  1  system clock, all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  N_REQ  per-requester request level; held high with data stable until ack.
REQ-007 req_data  in  N_REQ*D_BIT  requester i byte at bits [i*D_BIT +: D_BIT].
REQ-008 ack  out  N_REQ  one-cycle pulse to the requester whose byte completed.
REQ-009 err  out  1  one-cycle pulse on timeout abort.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 grant_idx  out  3  index of the current or last granted requester.
REQ-012 tx_start_n  out  1  active-low start strobe to the UART transmitter.
REQ-013 tx_data  out  D_BIT  byte presented to the transmitter.
REQ-014 tx_done_tick  in  1  one-cycle completion pulse from the transmitter.

Function
REQ-015 The FSM shall have states IDLE, START and BUSY; all outputs shall be registered.
REQ-016 IDLE: if any req bit is high, grant the first high bit searching upward from ptr with wrap; latch grant_idx and tx_data = req_data[grant]; go to START.
REQ-017 IDLE with req all zero: stay in IDLE; tx_start_n high.
REQ-018 START: tx_start_n low for exactly one cycle; next state BUSY.
REQ-019 Latency: req high in IDLE at edge k -> tx_start_n low during cycle k+1.
REQ-020 BUSY: a free-running counter starting at 0 shall count cycles; tx_data shall stay stable.
REQ-021 BUSY with tx_done_tick=1: ack[grant_idx] pulses for one cycle; ptr = (grant_idx+1) mod N_REQ; go to IDLE.
REQ-022 BUSY with counter = TIMEOUT-1 and no tx_done_tick: err pulses, no ack, ptr advances as in REQ-021, go to IDLE.
REQ-023 If tx_done_tick and timeout occur in the same cycle, done shall win: ack pulses and err does not.
REQ-024 tx_done_tick in IDLE or START shall be ignored.
REQ-025 A requester dropping req during START or BUSY shall not abort the transfer; ack still pulses.
REQ-026 Requesters shall deassert req the cycle after ack; a req still high in IDLE is treated as a new request.
REQ-027 Fairness: with all req held high, the grant order shall rotate 0,1,...,N_REQ-1,0; no requester waits more than N_REQ-1 transfers.
REQ-028 Minimum gap between transfers: one IDLE cycle between the ack and the next START.

Reset
REQ-029 While rst_n=0: state IDLE, tx_start_n=1, tx_data=0, ack=0, err=0, busy=0, grant_idx=0, ptr=0, counter=0.
REQ-030 Reset asserted mid-transfer shall abort immediately with no ack and no err; after release, arbitration restarts from ptr=0.

Structure
REQ-031 A shared package uart_pkg shall hold the FSM state encoding and the D_BIT default, shared with the other UART blocks.
REQ-032 A combinational sub-module rr_pick (inputs req and ptr, outputs grant index and valid) shall implement the wrapped priority search.

Verification
REQ-033 Single request: req=4'b0100, req_data[2]=8'hA5 -> grant_idx=2, tx_data=8'hA5, tx_start_n low one cycle; a tx_done_tick 100 cycles later -> ack=4'b0100 for one cycle.
REQ-034 All requesters held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3, exactly one ack per transfer.
REQ-035 Timeout with TIMEOUT=32 and tx_done_tick never asserted -> err pulses in the 32nd BUSY cycle, no ack, and the next grant goes to the next index.
REQ-036 tx_done_tick on the same cycle as the timeout terminal count -> ack pulses and err stays 0.
REQ-037 rst_n pulsed low during BUSY -> all outputs reach their reset values asynchronously, no ack; the first grant after release goes to the lowest active index.
REQ-038 Stray tx_done_tick in IDLE, and req dropped during BUSY -> no spurious ack in IDLE; ack still pulses on completion.
